// File: rtl/debounce_pkg.sv
// Shared types for the button debouncer: debounce FSM states and repeat phases.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_HIGH,
    PRESSED,
    WAIT_LOW
  } db_state_t;

  typedef enum logic {
    FIRST,
    RATE
  } rpt_phase_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Debounces one clk-synchronous button level into a stable level plus registered
// press/release strobes and an optional hold-to-repeat strobe.
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = 1_000_000,
  parameter bit REPEAT_EN           = 1'b0,
  parameter int REPEAT_DELAY_CYCLES = 50_000_000,
  parameter int REPEAT_RATE_CYCLES  = 10_000_000
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      in,
  output logic      debounced,
  output logic      press_pulse,
  output logic      release_pulse,
  output logic      repeat_pulse,
  output db_state_t dbg_state
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

  db_state_t        state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             deb_d, press_d, release_d;

  // Valid/ready does not apply here: in is a level, outputs are one-cycle strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      debounced     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      debounced     <= deb_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state)
      IDLE: begin
        if (in) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      WAIT_HIGH: begin
        if (!in) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end else if (cnt != CNT_MAX) begin
          cnt_d = cnt + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!in) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      WAIT_LOW: begin
        // A high sample here is a bounce: return to PRESSED silently.
        if (in) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt == CNT_LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else if (cnt != CNT_MAX) begin
          cnt_d = cnt + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    deb_d = (state_d == PRESSED) || (state_d == WAIT_LOW);
  end

  assign dbg_state = state;

  generate
    if (REPEAT_EN) begin : g_repeat
      localparam int RCNT_MAX = max2(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES);
      localparam int RCNT_W   = $clog2(RCNT_MAX + 1);
      localparam logic [RCNT_W:0] DELAY_T = (RCNT_W + 1)'(REPEAT_DELAY_CYCLES);
      localparam logic [RCNT_W:0] RATE_T  = (RCNT_W + 1)'(REPEAT_RATE_CYCLES);

      logic [RCNT_W-1:0] rcnt, rcnt_d;
      logic [RCNT_W:0]   rcnt_inc, target;
      rpt_phase_t        phase, phase_d;
      logic              rpt_d;

      always_ff @(posedge clk) begin
        if (rst) begin
          rcnt         <= '0;
          phase        <= FIRST;
          repeat_pulse <= 1'b0;
        end else begin
          rcnt         <= rcnt_d;
          phase        <= phase_d;
          repeat_pulse <= rpt_d;
        end
      end

      always_comb begin
        rcnt_d   = rcnt;
        phase_d  = phase;
        rpt_d    = 1'b0;
        rcnt_inc = {1'b0, rcnt} + {{RCNT_W{1'b0}}, 1'b1};
        target   = (phase == FIRST) ? DELAY_T : RATE_T;
        if (press_d) begin
          rcnt_d  = '0;
          phase_d = FIRST;
        end else if (state == PRESSED) begin
          if (rcnt_inc >= target) begin
            // If the same edge leaves PRESSED, hold so the strobe fires on return.
            if (state_d == PRESSED) begin
              rpt_d   = 1'b1;
              rcnt_d  = '0;
              phase_d = RATE;
            end
          end else begin
            rcnt_d = rcnt_inc[RCNT_W-1:0];
          end
        end
      end
    end else begin : g_no_repeat
      assign repeat_pulse = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer (N=4, DELAY=10, RATE=3) with a REPEAT_EN=0 twin.
module tb_button_debouncer;
  import debounce_pkg::*;

  logic      clk, rst, in;
  logic      debounced, press_pulse, release_pulse, repeat_pulse;
  logic      debounced0, press_pulse0, release_pulse0, repeat_pulse0;
  db_state_t dbg_state, dbg_state0;

  int        n_checks, n_fail;
  int        cyc, n_press, n_release, n_both, n_rep0, n_deb_hi, n_deb_lo;
  int        p;
  logic [31:0] rep_q[$];
  logic [31:0] exp_q[$];

  button_debouncer #(
    .DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b1),
    .REPEAT_DELAY_CYCLES(10), .REPEAT_RATE_CYCLES(3)
  ) dut (
    .clk(clk), .rst(rst), .in(in), .debounced(debounced),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .repeat_pulse(repeat_pulse), .dbg_state(dbg_state)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b0),
    .REPEAT_DELAY_CYCLES(10), .REPEAT_RATE_CYCLES(3)
  ) dut_norpt (
    .clk(clk), .rst(rst), .in(in), .debounced(debounced0),
    .press_pulse(press_pulse0), .release_pulse(release_pulse0),
    .repeat_pulse(repeat_pulse0), .dbg_state(dbg_state0)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance one clock and sample outputs 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (press_pulse) n_press++;
    if (release_pulse) n_release++;
    if (press_pulse && release_pulse) n_both++;
    if (repeat_pulse) rep_q.push_back(32'(cyc));
    if (repeat_pulse0) n_rep0++;
    if (debounced) n_deb_hi++;
    else n_deb_lo++;
  endtask

  task automatic check_repeats(input string tag);
    check({tag, "_count"}, 32'(rep_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0) begin
      if (rep_q.size() > 0) check({tag, "_cycle"}, rep_q.pop_front(), exp_q.pop_front());
      else void'(exp_q.pop_front());
    end
    rep_q.delete();
  endtask

  task automatic clear_counts();
    n_press = 0; n_release = 0; n_deb_hi = 0; n_deb_lo = 0;
    rep_q.delete();
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0; n_both = 0; n_rep0 = 0;
    clear_counts();
    rst = 1'b1;
    in  = 1'b1;

    // Reset with in held high
    repeat (3) tick();
    check("rst_deb", 32'(debounced), 0);
    check("rst_press", 32'(press_pulse), 0);
    check("rst_release", 32'(release_pulse), 0);
    check("rst_repeat", 32'(repeat_pulse), 0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));

    // Press arrives on the 4th edge after reset release
    rst = 1'b0;
    clear_counts();
    repeat (3) tick();
    check("pre_press_deb", 32'(debounced), 0);
    check("pre_press_pulses", 32'(n_press), 0);
    tick();
    check("press_pulse", 32'(press_pulse), 1);
    check("press_deb", 32'(debounced), 1);
    tick();
    check("press_width", 32'(press_pulse), 0);
    check("held_deb", 32'(debounced), 1);

    // Release after 4 low samples
    in = 1'b0;
    repeat (3) tick();
    check("pre_release_deb", 32'(debounced), 1);
    check("pre_release_pulse", 32'(n_release), 0);
    tick();
    check("release_pulse", 32'(release_pulse), 1);
    check("release_deb", 32'(debounced), 0);
    tick();
    check("release_width", 32'(release_pulse), 0);
    check("press_count_1", 32'(n_press), 1);
    check("release_count_1", 32'(n_release), 1);
    check_repeats("short_hold_repeats");

    // Bounce: 3 highs, low, 3 highs, low
    clear_counts();
    in = 1'b1; repeat (3) tick();
    in = 1'b0; tick();
    in = 1'b1; repeat (3) tick();
    in = 1'b0; repeat (6) tick();
    check("bounce_deb_hi", 32'(n_deb_hi), 0);
    check("bounce_press", 32'(n_press), 0);
    check("bounce_release", 32'(n_release), 0);

    // Hold: repeats at P+10, P+13, P+16
    clear_counts();
    in = 1'b1;
    repeat (4) tick();
    check("hold_press", 32'(press_pulse), 1);
    p = cyc;
    repeat (17) tick();
    exp_q.push_back(32'(p + 10));
    exp_q.push_back(32'(p + 13));
    exp_q.push_back(32'(p + 16));
    check_repeats("hold_repeats");
    in = 1'b0;
    repeat (4) tick();
    check("hold_release", 32'(release_pulse), 1);
    repeat (12) tick();
    check("hold_release_count", 32'(n_release), 1);
    check_repeats("after_release_repeats");

    // Two-cycle low glitch while pressed shifts the schedule by 2
    clear_counts();
    in = 1'b1;
    repeat (4) tick();
    check("glitch_press", 32'(press_pulse), 1);
    p = cyc;
    n_deb_lo = 0;
    repeat (5) tick();
    in = 1'b0; repeat (2) tick();
    in = 1'b1; repeat (12) tick();
    check("glitch_deb_lo", 32'(n_deb_lo), 0);
    check("glitch_release", 32'(n_release), 0);
    exp_q.push_back(32'(p + 12));
    exp_q.push_back(32'(p + 15));
    exp_q.push_back(32'(p + 18));
    check_repeats("glitch_repeats");

    // Reset while pressed: no release strobe
    rst = 1'b1;
    tick();
    check("midrst_deb", 32'(debounced), 0);
    check("midrst_release", 32'(release_pulse), 0);
    check("midrst_repeat", 32'(repeat_pulse), 0);
    check("midrst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    repeat (3) tick();
    check("repress_early", 32'(press_pulse), 0);
    tick();
    check("repress_pulse", 32'(press_pulse), 1);
    check("midrst_release_count", 32'(n_release), 0);

    // REPEAT_EN=0 twin and exclusivity
    check("norpt_repeats", 32'(n_rep0), 0);
    check("norpt_deb", 32'(debounced0), 1);
    check("press_release_overlap", 32'(n_both), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
